// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the video consumers
// master: generator side (drives every signal); slave: pixel fetch / output encoder side
// hsync, vsync     : sync pulses at the polarity chosen in the generator
// de               : data enable, high during active pixels
// x, y             : active pixel coordinates, 0 while de is low
// line_start       : one-cycle pulse on the first pixel of each active line
// frame_start      : one-cycle pulse on pixel (0,0)
// rgb              : colour-bar test pixel, only with TEST_PATTERN_EN
interface vga_timing_gen_if #(parameter int CNT_W = 10);
  logic hsync, vsync, de, line_start, frame_start;
  logic [CNT_W-1:0] x, y;
`ifdef TEST_PATTERN_EN
  logic [23:0] rgb;
  modport master(output hsync, vsync, de, x, y, line_start, frame_start, rgb);
  modport slave(input hsync, vsync, de, x, y, line_start, frame_start, rgb);
`else
  modport master(output hsync, vsync, de, x, y, line_start, frame_start);
  modport slave(input hsync, vsync, de, x, y, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the PLL pixel clock, held in restart until lock
// clkin    : pixel clock (PLL CLKOUTD)
// reset_n  : synchronous active-low reset
// pll_lock : PLL lock, low restarts the raster at (0,0)
// vid      : timing outputs (vga_timing_gen_if.master), all registered one clock after the counters
// TEST_PATTERN_EN : when defined, adds the registered 8-bar colour pattern on vid.rgb
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W = 10
) (
  input logic clkin,
  input logic reset_n,
  input logic pll_lock,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_B = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_B = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d = (h_cnt_q >= HS_B && h_cnt_q < HS_E) ? HS_POL : ~HS_POL;
    vsync_d = (v_cnt_q >= VS_B && v_cnt_q < VS_E) ? VS_POL : ~VS_POL;
    x_d = de_d ? h_cnt_q : '0;
    y_d = de_d ? v_cnt_q : '0;
    line_start_d = de_d && (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end
  always_ff @(posedge clkin) begin
    if (!reset_n || !pll_lock) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q <= de_d;
      x_q <= x_d;
      y_q <= y_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign vid.de = de_q;
  assign vid.x = x_q;
  assign vid.y = y_q;
  assign vid.line_start = line_start_q;
  assign vid.frame_start = frame_start_q;
`ifdef TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
  logic [2:0] bar;
  logic [23:0] rgb_q, rgb_d;
  // bar index bits map straight onto colour components: R off for bars 2,3,6,7, G off for 4..7, B off for odd
  always_comb begin
    bar = 3'(h_cnt_q / BAR_W);
    rgb_d = de_d ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h0;
  end
  always_ff @(posedge clkin) rgb_q <= (!reset_n || !pll_lock) ? 24'h0 : rgb_d;
  assign vid.rgb = rgb_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for default and shrunken-raster vga_timing_gen instances
module tb_vga_timing_gen;
  typedef struct packed {
    logic hs, vs, de;
    logic [9:0] x, y;
    logic ls, fs;
    logic [23:0] rgb;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0, lock_a = 1'b1, lock_b = 1'b1;
  int n_chk = 0, n_fail = 0, n_line = 0, n_frame = 0;
  int mha = 0, mva = 0, mhb = 0, mvb = 0;
  int a_cnt = -1, a_de, a_hs0, a_hsl;
  int b_cnt = -1, b_vs0, b_vsl, b_ls;
  exp_t qa[$], qb[$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  vga_timing_gen_if #(.CNT_W(10)) ifa();
  vga_timing_gen_if #(.CNT_W(10)) ifb();
  vga_timing_gen dut_a (.clkin(clk), .reset_n(reset_n), .pll_lock(lock_a), .vid(ifa));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(6), .V_FP(1),
    .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10))
    dut_b (.clkin(clk), .reset_n(reset_n), .pll_lock(lock_b), .vid(ifb));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t model(input int h, v, input bit r, input int ha, hfp, hsw, va, vfp, vsw,
                                 input bit hp, vp);
    exp_t e;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (!r) begin
      e.de = (h < ha) && (v < va);
      if (h >= ha + hfp && h < ha + hfp + hsw) e.hs = hp;
      if (v >= va + vfp && v < va + vfp + vsw) e.vs = vp;
      e.x = e.de ? 10'(h) : 10'd0;
      e.y = e.de ? 10'(v) : 10'd0;
      e.ls = e.de && h == 0;
      e.fs = h == 0 && v == 0;
`ifdef TEST_PATTERN_EN
      e.rgb = e.de ? bars[h / (ha / 8)] : 24'h0;
`endif
    end
    return e;
  endfunction
  task automatic adv(inout int h, v, input bit r, input int ht, vt);
    if (r) begin
      h = 0;
      v = 0;
    end else if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else h = h + 1;
  endtask
  task automatic cmp(input string p, input exp_t g, input exp_t e);
    chk({p, "_hsync"}, g.hs, e.hs);
    chk({p, "_vsync"}, g.vs, e.vs);
    chk({p, "_de"}, g.de, e.de);
    chk({p, "_x"}, g.x, e.x);
    chk({p, "_y"}, g.y, e.y);
    chk({p, "_line_start"}, g.ls, e.ls);
    chk({p, "_frame_start"}, g.fs, e.fs);
    chk({p, "_rgb"}, g.rgb, e.rgb);
  endtask
  task automatic step(input logic rn, la, lb);
    exp_t g;
    bit ra, rb;
    @(negedge clk);
    g = '0;
    g.hs = ifa.hsync; g.vs = ifa.vsync; g.de = ifa.de; g.x = ifa.x; g.y = ifa.y;
    g.ls = ifa.line_start; g.fs = ifa.frame_start;
`ifdef TEST_PATTERN_EN
    g.rgb = ifa.rgb;
`endif
    if (qa.size() > 0) cmp("a", g, qa.pop_front());
    g = '0;
    g.hs = ifb.hsync; g.vs = ifb.vsync; g.de = ifb.de; g.x = ifb.x; g.y = ifb.y;
    g.ls = ifb.line_start; g.fs = ifb.frame_start;
`ifdef TEST_PATTERN_EN
    g.rgb = ifb.rgb;
`endif
    if (qb.size() > 0) cmp("b", g, qb.pop_front());
    if (!reset_n || !lock_a) a_cnt = -1;
    else begin
      if (ifa.line_start) begin
        if (a_cnt > 0) begin
          chk("line_period", a_cnt, 800);
          chk("line_de_len", a_de, 640);
          chk("line_hs_start", a_hs0, 656);
          chk("line_hs_len", a_hsl, 96);
          n_line++;
        end
        a_cnt = 0; a_de = 0; a_hs0 = -1; a_hsl = 0;
      end
      if (a_cnt >= 0) begin
        if (ifa.de) a_de++;
        if (!ifa.hsync) begin
          if (a_hs0 < 0) a_hs0 = a_cnt;
          a_hsl++;
        end
        a_cnt++;
      end
    end
    if (!reset_n || !lock_b) b_cnt = -1;
    else begin
      if (ifb.frame_start) begin
        if (b_cnt > 0) begin
          chk("frame_period", b_cnt, 275);
          chk("frame_vs_start", b_vs0, 175);
          chk("frame_vs_len", b_vsl, 50);
          chk("frame_lines", b_ls, 6);
          n_frame++;
        end
        b_cnt = 0; b_vs0 = -1; b_vsl = 0; b_ls = 0;
      end
      if (b_cnt >= 0) begin
        if (ifb.line_start) b_ls++;
        if (ifb.vsync) begin
          if (b_vs0 < 0) b_vs0 = b_cnt;
          b_vsl++;
        end
        b_cnt++;
      end
    end
    reset_n = rn;
    lock_a = la;
    lock_b = lb;
    ra = !rn || !la;
    rb = !rn || !lb;
    qa.push_back(model(mha, mva, ra, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0));
    qb.push_back(model(mhb, mvb, rb, 16, 2, 4, 6, 1, 2, 1'b1, 1'b1));
    adv(mha, mva, ra, 800, 525);
    adv(mhb, mvb, rb, 25, 11);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    n = 0;
    while (!(mha == 300 && mva == 2) && n < 5000) begin
      step(1'b1, 1'b1, 1'b1);
      n++;
    end
    chk("reach_a_300_2", n < 5000, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 1200; i++) step(1'b1, 1'b1, 1'b1);
    n = 0;
    while (!(mhb == 10 && mvb == 3) && n < 1000) begin
      step(1'b1, 1'b1, 1'b1);
      n++;
    end
    chk("reach_b_10_3", n < 1000, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, 1'b1);
    chk("line_checks_seen", n_line >= 3, 1);
    chk("frame_checks_seen", n_frame >= 4, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
